uart_tx_arbiter: RTL

- Round-robin arbiter that shares one uart_tx serializer between NUM_REQ requesters.
- Selects one pending requester and latches its byte and parity setting.
- Drives the serializer's send_request/tx_data/parity_enable, tracks the frame through tx_busy/tx_done, then acknowledges the requester.
- Sits between client blocks (console, debug, status reporters) and the single UART TX pin.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ requesters.
// Define UART_TX_ARBITER_TIMEOUT_EN to add a per-phase handshake timeout with err pulse.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_parity,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         err,
    output logic                         send_request,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         parity_enable,
    input  logic                         tx_busy,
    input  logic                         tx_done
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StArb, StReq, StBusy, StAck} state_e;

    state_e               state_q, state_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 send_request_q, send_request_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 parity_enable_q, parity_enable_d;

    logic                 pick_valid;
    logic [IdxW-1:0]      pick_idx;
    logic [IdxW-1:0]      cand_idx;
    int                   cand;

    // Scan from farthest to nearest so the nearest pending requester after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = 0;
        cand_idx   = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand     = (int'(rr_ptr_q) + k) % int'(NUM_REQ);
            cand_idx = IdxW'(cand);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        timeout;

    assign timeout = (cnt_q == TIMEOUT_CYCLES - 32'd1);
`endif

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        ack_d           = '0;
        send_request_d  = send_request_q;
        tx_data_d       = tx_data_q;
        parity_enable_d = parity_enable_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        cnt_d           = cnt_q + 32'd1;
        err_d           = 1'b0;
`endif
        unique case (state_q)
            StArb: begin
                if (pick_valid) begin
                    state_d            = StReq;
                    rr_ptr_d           = pick_idx;
                    grant_d            = '0;
                    grant_d[pick_idx]  = 1'b1;
                    tx_data_d          = req_data[pick_idx*DATA_BITS +: DATA_BITS];
                    parity_enable_d    = req_parity[pick_idx];
                    send_request_d     = 1'b1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    cnt_d              = '0;
`endif
                end
            end
            // A stale tx_done from the previous frame must not advance this state.
            StReq: begin
                if (tx_busy) begin
                    send_request_d = 1'b0;
                    state_d        = StBusy;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            StBusy: begin
                if (tx_done) begin
                    ack_d[rr_ptr_q] = 1'b1;
                    grant_d         = '0;
                    state_d         = StAck;
                end
            end
            StAck: begin
                state_d = StArb;
            end
            default: begin
                state_d = StArb;
            end
        endcase
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        if ((state_q == StReq || state_q == StBusy) && timeout) begin
            err_d           = 1'b1;
            send_request_d  = 1'b0;
            grant_d         = '0;
            ack_d           = '0;
            ack_d[rr_ptr_q] = 1'b1;
            state_d         = StArb;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StArb;
            rr_ptr_q        <= IdxW'(NUM_REQ - 1);
            grant_q         <= '0;
            ack_q           <= '0;
            send_request_q  <= 1'b0;
            tx_data_q       <= '0;
            parity_enable_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            ack_q           <= ack_d;
            send_request_q  <= send_request_d;
            tx_data_q       <= tx_data_d;
            parity_enable_q <= parity_enable_d;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign grant         = grant_q;
    assign ack           = ack_q;
    assign send_request  = send_request_q;
    assign tx_data       = tx_data_q;
    assign parity_enable = parity_enable_q;

endmodule
